turn_sequencer: RTL

//  Game-flow controller for the 5x5 board register block. It runs turns as player 1, then player 2, alternating.
//  - Filters placement requests: range check and occupancy check against the current board.
//  - Issues a one-cycle place strobe to the board, then samples the win checker.
//  - Counts turns, declares win or draw, and enforces an optional per-turn move timeout.

---
 rtl/turn_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/turn_sequencer.sv
// Turn-based game-flow controller for a 5x5 board: alternates player turns, filters
// placement requests, strobes the board, samples the win checker and declares the result.
module turn_sequencer #(
    parameter logic [31:0] TURN_TIMEOUT = 32'd0,
    parameter int          MAX_TURNS    = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        place_btn,
    input  logic [4:0]  cursor_loc,
    input  logic [49:0] board_flat,
    input  logic        win_p1,
    input  logic        win_p2,
    output logic        clr,
    output logic        select_player,
    output logic        enable_player,
    output logic        player2Select,
    output logic        player2Enable,
    output logic        place,
    output logic [17:0] playerLocation,
    output logic [4:0]  turn_count,
    output logic        illegal_move,
    output logic        timeout_flag,
    output logic        game_over,
    output logic [1:0]  winner
);

    localparam int NUM_CELLS = 25;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_P1, S_P2, S_COMMIT, S_CHECK, S_OVER
    } state_t;

    state_t      state_q, state_d;
    logic        start_q, btn_q;
    logic [31:0] timer_q, timer_d;
    logic        mover_q, mover_d;          // 0: player 1 moved last, 1: player 2
    logic [4:0]  turn_q, turn_d;
    logic [1:0]  winner_q, winner_d;

    logic        clr_q, clr_d;
    logic        sel1_q, sel1_d, en1_q, en1_d;
    logic        sel2_q, sel2_d, en2_q, en2_d;
    logic        place_q, place_d;
    logic [17:0] loc_q, loc_d;
    logic        ill_q, ill_d;
    logic        to_q, to_d;
    logic        over_q, over_d;

    logic        start_rise, btn_rise, in_turn;
    logic        cursor_ok, legal, timeout_hit;
    logic [1:0]  cell_val;
    logic        mover_win, other_win;

    assign start_rise = start & ~start_q;
    assign btn_rise   = place_btn & ~btn_q;
    assign in_turn    = (state_q == S_P1) || (state_q == S_P2);
    assign cursor_ok  = (cursor_loc >= 5'd1) && (cursor_loc <= 5'(NUM_CELLS));

    always_comb begin
        cell_val = 2'b00;
        for (int i = 1; i <= NUM_CELLS; i++) begin
            if (cursor_loc == 5'(i)) cell_val = board_flat[2*i-2 +: 2];
        end
    end

    assign legal       = btn_rise && cursor_ok && (cell_val == 2'b00);
    assign timeout_hit = (TURN_TIMEOUT != 32'd0) && (timer_q == TURN_TIMEOUT - 32'd1);
    assign mover_win   = mover_q ? win_p2 : win_p1;
    assign other_win   = mover_q ? win_p1 : win_p2;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            btn_q    <= 1'b0;
            timer_q  <= '0;
            mover_q  <= 1'b0;
            turn_q   <= '0;
            winner_q <= 2'b00;
            clr_q    <= 1'b0;
            sel1_q   <= 1'b0;
            en1_q    <= 1'b0;
            sel2_q   <= 1'b0;
            en2_q    <= 1'b0;
            place_q  <= 1'b0;
            loc_q    <= '0;
            ill_q    <= 1'b0;
            to_q     <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            btn_q    <= place_btn;
            timer_q  <= timer_d;
            mover_q  <= mover_d;
            turn_q   <= turn_d;
            winner_q <= winner_d;
            clr_q    <= clr_d;
            sel1_q   <= sel1_d;
            en1_q    <= en1_d;
            sel2_q   <= sel2_d;
            en2_q    <= en2_d;
            place_q  <= place_d;
            loc_q    <= loc_d;
            ill_q    <= ill_d;
            to_q     <= to_d;
            over_q   <= over_d;
        end
    end

    // Next-state logic; a start rise overrides everything else
    always_comb begin
        state_d  = state_q;
        mover_d  = mover_q;
        winner_d = winner_q;
        turn_d   = turn_q;
        if (start_rise) begin
            state_d = S_CLEAR;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_IDLE;
                S_CLEAR:  state_d = S_P1;
                S_P1: begin
                    mover_d = 1'b0;
                    if (legal)            state_d = S_COMMIT;
                    else if (timeout_hit) state_d = S_P2;
                end
                S_P2: begin
                    mover_d = 1'b1;
                    if (legal)            state_d = S_COMMIT;
                    else if (timeout_hit) state_d = S_P1;
                end
                S_COMMIT: state_d = S_CHECK;
                S_CHECK: begin
                    if (mover_win) begin
                        state_d  = S_OVER;
                        winner_d = mover_q ? 2'b10 : 2'b01;
                    end else if (other_win) begin
                        state_d  = S_OVER;
                        winner_d = mover_q ? 2'b01 : 2'b10;
                    end else if (turn_q == 5'(MAX_TURNS)) begin
                        state_d  = S_OVER;
                        winner_d = 2'b11;
                    end else begin
                        state_d = mover_q ? S_P1 : S_P2;
                    end
                end
                S_OVER:   state_d = S_OVER;
                default:  state_d = S_IDLE;
            endcase
        end
        if (state_d == S_CLEAR) begin
            turn_d   = '0;
            winner_d = 2'b00;
        end else if (state_q == S_COMMIT && state_d == S_CHECK && turn_q < 5'(NUM_CELLS)) begin
            turn_d = turn_q + 5'd1;
        end
        // The turn timer only runs while the same turn persists
        if (in_turn && state_d == state_q) timer_d = timer_q + 32'd1;
        else                               timer_d = '0;
    end

    // Output logic, computed from the upcoming state so every output is a register
    always_comb begin
        clr_d   = (state_d == S_CLEAR);
        place_d = (state_d == S_COMMIT);
        loc_d   = place_d ? {13'b0, cursor_loc} : 18'b0;
        ill_d   = in_turn && !start_rise && btn_rise && !legal;
        to_d    = in_turn && !start_rise && !legal && timeout_hit;
        over_d  = (state_d == S_OVER);
        sel1_d  = 1'b0;
        en1_d   = 1'b0;
        sel2_d  = 1'b0;
        en2_d   = 1'b0;
        case (state_d)
            S_P1: begin
                sel1_d = 1'b1;
                en1_d  = 1'b1;
            end
            S_P2: begin
                sel2_d = 1'b1;
                en2_d  = 1'b1;
            end
            S_COMMIT, S_CHECK: begin
                sel1_d = ~mover_d;
                en1_d  = ~mover_d;
                sel2_d = mover_d;
                en2_d  = mover_d;
            end
            default: ;
        endcase
    end

    assign clr            = clr_q;
    assign select_player  = sel1_q;
    assign enable_player  = en1_q;
    assign player2Select  = sel2_q;
    assign player2Enable  = en2_q;
    assign place          = place_q;
    assign playerLocation = loc_q;
    assign turn_count     = turn_q;
    assign illegal_move   = ill_q;
    assign timeout_flag   = to_q;
    assign game_over      = over_q;
    assign winner         = winner_q;

endmodule
